uart_tx_scheduler: RTL and testbench
====================================

UART_TX_SCHEDULER -- requirements
Module: uart_tx_scheduler

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 4096, is the per-frame completion timeout in clocks and is used only when UART_TX_SCHED_TIMEOUT_EN is defined.
REQ-002 clock  in  1  system clock; all logic SHALL be on posedge.
REQ-003 reset  in  1  synchronous, active-low reset.
REQ-004 req0_valid  in  1  requester 0 has a byte; SHALL be held until accepted.
REQ-005 req0_byte  in  8  requester 0 data.
REQ-006 req0_ready  out  1  accept strobe to requester 0.
REQ-007 req1_valid, req1_byte, req1_ready  same as REQ-004..006, for requester 1.
REQ-008 uart_byte  out  8  byte presented to the UART transmitter core.
REQ-009 uart_en_n  out  1  active-low start strobe to the transmitter core.
REQ-010 uart_complete  in  1  core level: high when idle or frame done; low while sending.
REQ-011 busy  out  1  high from accept until return to IDLE.
REQ-012 last_grant  out  1  index of the most recently granted requester.
REQ-013 timeout_err  out  1  sticky completion-timeout flag.

Function
REQ-014 States: IDLE, START, ARM, WAIT; all other encodings SHALL go to IDLE.
REQ-015 IDLE: reqN_ready SHALL be combinational: high for the granted valid requester only, low otherwise.
REQ-016 Arbitration, both valid: the grant SHALL go to the requester not equal to last_grant (round robin).
REQ-017 Arbitration, one valid: that requester SHALL be granted regardless of last_grant.
REQ-018 Accept (valid & ready) at cycle T: byte captured into uart_byte, last_grant updated, busy=1, state START at T+1.
REQ-019 START: uart_en_n=0 for exactly one cycle (T+1), then ARM.
REQ-020 uart_en_n SHALL be 1 in every other state.
REQ-021 ARM: wait for uart_complete=0, then WAIT.
REQ-022 WAIT: wait for uart_complete=1, then IDLE with busy=0 on the next cycle.
REQ-023 A new accept SHALL be possible in the first IDLE cycle.
REQ-024 uart_byte SHALL hold its value from capture until the next accept.
REQ-025 No ready SHALL assert outside IDLE; valid changes outside IDLE SHALL be ignored.
REQ-026 A requester that drops valid before acceptance SHALL not be granted and SHALL leave last_grant unchanged.

Reset
REQ-027 With reset=0 at a clock edge: state=IDLE, uart_en_n=1, uart_byte=0, busy=0, last_grant=1, timeout_err=0.
REQ-028 During the reset cycle, both readys SHALL be 0.
REQ-029 Reset mid-frame (START/ARM/WAIT) SHALL abandon the captured byte without re-sending it.
REQ-030 last_grant=1 after reset, so requester 0 wins the first contention.

Configuration
REQ-031 Macro UART_TX_SCHED_TIMEOUT_EN defined: a cycle counter SHALL clear on entry to ARM and count in ARM and WAIT.
REQ-032 With the macro, on reaching TIMEOUT_CYCLES: timeout_err set (sticky until reset), state forced to IDLE, busy=0.
REQ-033 Without the macro: no counter, ARM/WAIT wait indefinitely, timeout_err tied 0; the port SHALL remain present.

Structure
REQ-034 Package uart_pkg SHALL hold the state enum UartSchedState and the constant UART_SCHED_TIMEOUT_DEFAULT=4096.
REQ-035 The round-robin grant logic SHALL be sub-module rr_arbiter2: inputs req[1:0], last_grant; output grant[1:0] one-hot or zero.

Verification
REQ-036 Reset, then req0_valid=1, byte 0xA9 -> req0_ready at T, uart_en_n low at T+1 only, uart_byte=0xA9, last_grant=0.
REQ-037 Both valid (0x55, 0xAA) after reset -> frame order 0x55 then 0xAA, one-cycle ready each, last_grant 0 then 1.
REQ-038 Core model holds uart_complete low 20 cycles -> busy high throughout, exactly one start strobe, IDLE 1 cycle after complete rises.
REQ-039 reset=0 asserted while in WAIT -> next cycle IDLE, busy=0, uart_byte=0, no second strobe for the abandoned byte.
REQ-040 With UART_TX_SCHED_TIMEOUT_EN and TIMEOUT_CYCLES=16, uart_complete stuck high -> timeout_err=1 after 16 ARM cycles, IDLE, next request still serviced.
REQ-041 Without UART_TX_SCHED_TIMEOUT_EN and the same stimulus as REQ-040 -> the block remains in ARM for 1000 cycles and timeout_err stays 0.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared state type and constants for the UART transmit scheduler
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    ARM   = 2'd2,
    WAIT  = 2'd3
  } UartSchedState;

  localparam int unsigned UART_SCHED_TIMEOUT_DEFAULT = 4096;

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-way round-robin grant; grant is one-hot or zero
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] grant
);

  // Contention goes to whichever requester was not served last.
  always_comb begin
    grant = req;
    if (req == 2'b11) begin
      grant = last_grant ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// rtl/uart_tx_scheduler.sv - arbitrates two byte requesters onto one UART transmitter core
// Optional completion timeout enabled by macro UART_TX_SCHED_TIMEOUT_EN.
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = UART_SCHED_TIMEOUT_DEFAULT
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       req0_valid,
  input  logic [7:0] req0_byte,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_byte,
  output logic       req1_ready,
  output logic [7:0] uart_byte,
  output logic       uart_en_n,
  input  logic       uart_complete,
  output logic       busy,
  output logic       last_grant,
  output logic       timeout_err
);

  UartSchedState state_q, state_d;
  logic [7:0]    uart_byte_q, uart_byte_d;
  logic          last_grant_q, last_grant_d;
  logic          timeout_err_q, timeout_err_d;
  logic [1:0]    grant;
  logic          accept;
  logic          timeout_hit;

  rr_arbiter2 u_arb (
    .req        ({req1_valid, req0_valid}),
    .last_grant (last_grant_q),
    .grant      (grant)
  );

  // Readys are gated by reset so nothing is accepted on the reset edge.
  assign accept = (state_q == IDLE) && reset && (grant != 2'b00);

`ifdef UART_TX_SCHED_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;

  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (state_q == START) begin
      tmo_cnt_d = '0;
    end else if ((state_q == ARM) || (state_q == WAIT)) begin
      tmo_cnt_d = tmo_cnt_q + 1'b1;
    end
  end

  assign timeout_hit = ((state_q == ARM) || (state_q == WAIT)) &&
                       (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock) begin
    if (!reset) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout_hit        = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = START;
      START:   state_d = ARM;
      ARM:     if (!uart_complete) state_d = WAIT;
      WAIT:    if (uart_complete) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (timeout_hit) begin
      state_d = IDLE;
    end
  end

  always_comb begin
    uart_byte_d   = uart_byte_q;
    last_grant_d  = last_grant_q;
    timeout_err_d = timeout_err_q | timeout_hit;
    if (accept) begin
      uart_byte_d  = grant[1] ? req1_byte : req0_byte;
      last_grant_d = grant[1];
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      uart_byte_q   <= 8'h00;
      last_grant_q  <= 1'b1;
      timeout_err_q <= 1'b0;
    end else begin
      uart_byte_q   <= uart_byte_d;
      last_grant_q  <= last_grant_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    uart_en_n  = 1'b1;
    busy       = 1'b1;
    case (state_q)
      IDLE: begin
        busy       = 1'b0;
        req0_ready = grant[0] & reset;
        req1_ready = grant[1] & reset;
      end
      START:   uart_en_n = 1'b0;
      default: ;
    endcase
  end

  assign uart_byte   = uart_byte_q;
  assign last_grant  = last_grant_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb/tb_uart_tx_scheduler.sv - self-checking bench for uart_tx_scheduler
module tb_uart_tx_scheduler;

`ifdef UART_TX_SCHED_TIMEOUT_EN
  localparam int TMO       = 16;
  localparam int LONG_HOLD = 12;
`else
  localparam int TMO       = 4096;
  localparam int LONG_HOLD = 20;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic [7:0] req0_byte = 8'h00, req1_byte = 8'h00;
  logic       req0_ready, req1_ready;
  logic [7:0] uart_byte;
  logic       uart_en_n;
  logic       uart_complete;
  logic       busy, last_grant, timeout_err;

  int         compared = 0;
  int         mismatched = 0;
  int         strobes = 0;
  int         en_run = 0;
  int         en_run_max = 0;
  int         core_hold = 4;
  bit         core_stuck = 1'b0;
  bit         exp_last = 1'b1;
  logic [7:0] sent_q[$];
  logic [7:0] exp_q[$];

  uart_tx_scheduler #(.TIMEOUT_CYCLES(TMO)) dut (
    .clock         (clock),
    .reset         (reset),
    .req0_valid    (req0_valid),
    .req0_byte     (req0_byte),
    .req0_ready    (req0_ready),
    .req1_valid    (req1_valid),
    .req1_byte     (req1_byte),
    .req1_ready    (req1_ready),
    .uart_byte     (uart_byte),
    .uart_en_n     (uart_en_n),
    .uart_complete (uart_complete),
    .busy          (busy),
    .last_grant    (last_grant),
    .timeout_err   (timeout_err)
  );

  always #5 clock = ~clock;

  // Strobe monitor: records every byte the core is told to send.
  always @(negedge clock) begin
    if (uart_en_n === 1'b0) begin
      strobes++;
      sent_q.push_back(uart_byte);
      en_run++;
      if (en_run > en_run_max) en_run_max = en_run;
    end else begin
      en_run = 0;
    end
  end

  // Transmitter core model: goes busy one cycle after the strobe, for core_hold cycles.
  initial begin
    uart_complete = 1'b1;
    forever begin
      @(negedge clock);
      if (uart_en_n === 1'b0 && !core_stuck) begin
        @(negedge clock);
        uart_complete = 1'b0;
        repeat (core_hold) @(negedge clock);
        uart_complete = 1'b1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clock);
    #1;
  endtask

  // One arbitration round: model predicts frame order, then the round is driven and compared.
  task automatic frame(input bit v0, input bit v1, input logic [7:0] b0, input logic [7:0] b1,
                       input int hold, input bit glitch);
    int r0c, r1c, bc, guard, s0;
    bit a0, a1, first;
    exp_q.delete();
    sent_q.delete();
    en_run_max = 0;
    s0 = strobes;
    core_hold = hold;
    if (v0 && v1) begin
      first = !exp_last;
      exp_q.push_back(first ? b1 : b0);
      exp_q.push_back(first ? b0 : b1);
      exp_last = !first;
    end else if (v0) begin
      exp_q.push_back(b0);
      exp_last = 1'b0;
    end else if (v1) begin
      exp_q.push_back(b1);
      exp_last = 1'b1;
    end
    r0c = 0; r1c = 0; bc = 0; guard = 0;
    req0_valid = v0; req0_byte = b0;
    req1_valid = v1; req1_byte = b1;
    #1;
    while ((req0_valid || req1_valid || busy) && guard < 400) begin
      a0 = req0_ready;
      a1 = req1_ready;
      if (a0) r0c++;
      if (a1) r1c++;
      if (busy) bc++;
      step();
      guard++;
      if (a0) req0_valid = 1'b0;
      if (a1) req1_valid = 1'b0;
      // An idle requester raises then withdraws valid while the block is busy.
      if (glitch && !(v0 && v1)) begin
        if (bc == 2) begin
          if (v0) req1_valid = 1'b1; else req0_valid = 1'b1;
        end else if (bc == 3) begin
          if (v0) req1_valid = 1'b0; else req0_valid = 1'b0;
        end
      end
    end
    chk("frame_guard", guard < 400, 1);
    chk("req0_ready_cycles", r0c, v0);
    chk("req1_ready_cycles", r1c, v1);
    chk("busy_cycles", bc, exp_q.size() * (hold + 2));
    chk("strobe_count", strobes - s0, exp_q.size());
    chk("strobe_width", en_run_max, 1);
    chk("sent_count", sent_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < sent_q.size(); i++)
      chk("frame_byte", sent_q[i], exp_q[i]);
    chk("last_grant", last_grant, exp_last);
    if (exp_q.size() > 0) chk("uart_byte_hold", uart_byte, exp_q[exp_q.size()-1]);
  endtask

  initial begin
    int s0, bc, guard, bad_busy, bad_err, pat;
    logic [7:0] rb0, rb1;

    // Reset with both requesters asserting: no ready, reset values on outputs.
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_byte = 8'($urandom); req1_byte = 8'($urandom);
    step();
    step();
    chk("rst_req0_ready", req0_ready, 0);
    chk("rst_req1_ready", req1_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_uart_en_n", uart_en_n, 1);
    chk("rst_uart_byte", uart_byte, 8'h00);
    chk("rst_last_grant", last_grant, 1);
    chk("rst_timeout_err", timeout_err, 0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    reset = 1'b1;
    step();

    // Single requester 0 with 0xA9.
    exp_last = 1'b1;
    frame(1'b1, 1'b0, 8'hA9, 8'($urandom), 3, 1'b0);

    // Long core busy period with a withdrawn request from the other side.
    frame(1'b0, 1'b1, 8'($urandom), 8'($urandom), LONG_HOLD, 1'b1);

    // Reset while the core is in the middle of a frame.
    core_hold = 30;
    req0_valid = 1'b1; req0_byte = 8'h3C;
    step();
    req0_valid = 1'b0;
    repeat (5) step();
    chk("pre_reset_busy", busy, 1);
    s0 = strobes;
    reset = 1'b0;
    step();
    chk("midframe_rst_busy", busy, 0);
    chk("midframe_rst_byte", uart_byte, 8'h00);
    chk("midframe_rst_last_grant", last_grant, 1);
    reset = 1'b1;
    repeat (40) step();
    chk("no_resend_after_rst", strobes - s0, 0);
    chk("idle_after_rst", busy, 0);
    exp_last = 1'b1;

    // Contention right after reset: requester 0 first.
    frame(1'b1, 1'b1, 8'h55, 8'hAA, $urandom_range(1, 8), 1'b0);

    // Randomised rounds against the model.
    for (int n = 0; n < 16; n++) begin
      pat = $urandom_range(0, 2);
      rb0 = 8'($urandom);
      rb1 = 8'($urandom);
      frame(pat != 1, pat != 0, rb0, rb1, $urandom_range(1, 8), 1'($urandom));
    end

    // Core never reports busy: completion never arrives.
    core_stuck = 1'b1;
    s0 = strobes;
    req0_valid = 1'b1; req0_byte = 8'h77;
    step();
    req0_valid = 1'b0;
    exp_last = 1'b0;
`ifdef UART_TX_SCHED_TIMEOUT_EN
    bc = 0; guard = 0;
    while (busy && guard < 200) begin
      bc++;
      step();
      guard++;
    end
    chk("tmo_busy_cycles", bc, 1 + TMO);
    chk("tmo_err_set", timeout_err, 1);
    chk("tmo_idle", busy, 0);
    chk("tmo_strobes", strobes - s0, 1);
    core_stuck = 1'b0;
    frame(1'b0, 1'b1, 8'($urandom), 8'hC3, 4, 1'b0);
    chk("tmo_err_sticky", timeout_err, 1);
`else
    bad_busy = 0; bad_err = 0;
    for (int c = 0; c < 1000; c++) begin
      step();
      if (busy !== 1'b1) bad_busy++;
      if (timeout_err !== 1'b0) bad_err++;
    end
    chk("stuck_busy_drops", bad_busy, 0);
    chk("stuck_timeout_err", bad_err, 0);
    chk("stuck_strobes", strobes - s0, 1);
    chk("stuck_uart_byte", uart_byte, 8'h77);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
